// File: rtl/rcg_opcg_pkg.sv
// Shared types and defaults for the OPCG clock-gate controller.
package rcg_opcg_pkg;

   localparam int DEF_NUM_CH = 4;
   localparam int DEF_CNT_W  = 4;
   localparam int DEF_PLS_W  = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRE   = 2'd1,
      ST_PULSE = 2'd2,
      ST_POST  = 2'd3
   } opcg_state_e;

   // Increment v, holding at the all-ones value of a w-bit counter.
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
      logic [31:0] max_v;
      max_v = (32'd1 << w) - 32'd1;
      return (v >= max_v) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/crg_sync2.sv
// Two-flop synchroniser with synchronous active-high clear.
module crg_sync2 (
   input  logic clk_in,
   input  logic grst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk_in) begin
      if (grst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/rcg_opcg_ch_cnt.sv
// Per-channel pulse counter: holds the latched pulse count and counts pulses fired.
module rcg_opcg_ch_cnt
   import rcg_opcg_pkg::*;
#(
   parameter int PLS_W = DEF_PLS_W
) (
   input  logic             clk_in,
   input  logic             grst,
   input  logic             clr,
   input  logic             load,
   input  logic [PLS_W-1:0] n_in,
   input  logic             start,
   input  logic             tick,
   output logic             pulse,
   output logic             last,
   output logic             fin
);

   logic [PLS_W-1:0] n_q;
   logic [PLS_W-1:0] cnt_q;
   logic [PLS_W:0]   cnt_nxt;

   assign fin     = (cnt_q >= n_q);
   assign pulse   = start & tick;
   assign cnt_nxt = {1'b0, cnt_q} + {{PLS_W{1'b0}}, pulse};
   // True once this channel has nothing left to fire after the current cycle.
   assign last    = (cnt_nxt >= {1'b0, n_q});

   always_ff @(posedge clk_in) begin
      if (grst) begin
         n_q   <= '0;
         cnt_q <= '0;
      end else if (load) begin
         n_q   <= n_in;
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (pulse) begin
         cnt_q <= PLS_W'(sat_inc(32'(cnt_q), PLS_W));
      end
   end

endmodule

// File: rtl/rcg_ctrl_opcg_mc.sv
// Multi-channel OPCG clock-gate sequencer: pre gap, per-channel pulses, post gap.
// Define RCG_OPCG_STAGGER_EN to fire channels one after another instead of together.
module rcg_ctrl_opcg_mc
   import rcg_opcg_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int CNT_W  = DEF_CNT_W,
   parameter int PLS_W  = DEF_PLS_W
) (
   input  logic                    clk_in,
   input  logic                    grst,
   input  logic                    scan_mode,
   input  logic                    scan_enable,
   input  logic                    opcg_mode,
   input  logic                    opcg_trigger,
   input  logic                    gclk_div_cg_en,
   input  logic [NUM_CH-1:0]       cfg_ch_en,
   input  logic [NUM_CH*PLS_W-1:0] cfg_pls_num,
   input  logic [CNT_W-1:0]        cfg_pre_gap,
   input  logic [CNT_W-1:0]        cfg_post_gap,
   output logic [NUM_CH-1:0]       opcg_clk_cg_en,
   output logic                    opcg_busy,
   output logic                    opcg_done
);

   logic sm_s, se_s, om_s, trig_s;
   logic tick, go, go_s0, go_s1, go_pulse, abort, run, all_last;
   logic ld, clr, done_d;
   opcg_state_e      state_q, state_d;
   logic [CNT_W-1:0] gcnt_q, gcnt_d, pre_q, post_q;
   logic [NUM_CH-1:0] ch_start, ch_pulse, ch_last, ch_fin;

   crg_sync2 u_sync_sm   (.clk_in(clk_in), .grst(grst), .d(scan_mode),    .q(sm_s));
   crg_sync2 u_sync_se   (.clk_in(clk_in), .grst(grst), .d(scan_enable),  .q(se_s));
   crg_sync2 u_sync_om   (.clk_in(clk_in), .grst(grst), .d(opcg_mode),    .q(om_s));
   crg_sync2 u_sync_trig (.clk_in(clk_in), .grst(grst), .d(opcg_trigger), .q(trig_s));

   assign tick      = gclk_div_cg_en;
   assign go        = trig_s & ~se_s & sm_s & om_s;
   assign go_pulse  = go_s0 & ~go_s1;
   assign opcg_busy = (state_q != ST_IDLE);
   // go_s0 takes the value of go on this tick, so ~go here is go_s0 falling.
   assign abort     = tick & opcg_busy & ~go;
   assign run       = (state_q == ST_PULSE) & ~abort;
   assign all_last  = &ch_last;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [PLS_W-1:0] n_cfg;
      assign n_cfg = cfg_ch_en[c] ? cfg_pls_num[c*PLS_W +: PLS_W] : '0;

      rcg_opcg_ch_cnt #(.PLS_W(PLS_W)) u_cnt (
         .clk_in (clk_in),
         .grst   (grst),
         .clr    (clr),
         .load   (ld),
         .n_in   (n_cfg),
         .start  (ch_start[c]),
         .tick   (tick),
         .pulse  (ch_pulse[c]),
         .last   (ch_last[c]),
         .fin    (ch_fin[c])
      );

`ifdef RCG_OPCG_STAGGER_EN
      if (c == 0) begin : g_first
         assign ch_start[c] = run & ~ch_fin[c];
      end else begin : g_next
         assign ch_start[c] = run & ~ch_fin[c] & (&ch_fin[c-1:0]);
      end
`else
      assign ch_start[c] = run & ~ch_fin[c];
`endif
   end

   always_comb begin
      state_d = state_q;
      gcnt_d  = gcnt_q;
      ld      = 1'b0;
      clr     = 1'b0;
      done_d  = 1'b0;
      if (tick) begin
         case (state_q)
            ST_IDLE: if (go_pulse) begin
               state_d = ST_PRE;
               gcnt_d  = '0;
               ld      = 1'b1;
            end
            ST_PRE: if (gcnt_q == pre_q) begin
               state_d = ST_PULSE;
               gcnt_d  = '0;
            end else begin
               gcnt_d = CNT_W'(sat_inc(32'(gcnt_q), CNT_W));
            end
            ST_PULSE: if (all_last) begin
               state_d = ST_POST;
               gcnt_d  = '0;
            end
            ST_POST: if (gcnt_q == post_q) begin
               state_d = ST_IDLE;
               gcnt_d  = '0;
               done_d  = 1'b1;
            end else begin
               gcnt_d = CNT_W'(sat_inc(32'(gcnt_q), CNT_W));
            end
            default: begin
               state_d = ST_IDLE;
               gcnt_d  = '0;
               clr     = 1'b1;
            end
         endcase
         if (abort) begin
            state_d = ST_IDLE;
            gcnt_d  = '0;
            clr     = 1'b1;
            done_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (grst) begin
         state_q        <= ST_IDLE;
         gcnt_q         <= '0;
         pre_q          <= '0;
         post_q         <= '0;
         go_s0          <= 1'b0;
         go_s1          <= 1'b0;
         opcg_clk_cg_en <= '0;
         opcg_done      <= 1'b0;
      end else begin
         state_q        <= state_d;
         gcnt_q         <= gcnt_d;
         if (ld) begin
            pre_q  <= cfg_pre_gap;
            post_q <= cfg_post_gap;
         end
         if (tick) begin
            go_s0 <= go;
            go_s1 <= go_s0;
         end
         opcg_clk_cg_en <= ch_pulse;
         opcg_done      <= done_d;
      end
   end

endmodule
